register_file_mp: RTL and testbench

- Parametrised successor to the datapath register file. Generalised width, depth and read-port count.
- Adds write-to-read bypass and a multi-cycle sequential clear engine with busy flag.
- Adds a registered debug read port with request/valid handshake, used by the debug unit to dump architectural state without touching datapath read ports.
- Sits in the ID stage; ports 0/1 feed rs/rt, extra ports serve future dual-issue/debug needs.

---
 rtl/register_file_mp.sv | 129 ++++++++++++
 tb/tb_register_file_mp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port ID-stage register file with write bypass, sequential clear engine and debug read port.
// Optional build macro RF_ZERO_REG_EN hardwires entry 0 to zero.
module register_file_mp #(
    parameter int NB_BITS   = 32,
    parameter int NB_DEPTH  = 5,
    parameter int NB_RPORTS = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NB_RPORTS*NB_DEPTH-1:0] i_raddr,
    output logic [NB_RPORTS*NB_BITS-1:0]  o_rdata,
    output logic                          o_eq,
    input  logic [NB_DEPTH-1:0]           i_waddr,
    input  logic [NB_BITS-1:0]            i_data,
    input  logic                          i_wenb,
    input  logic                          i_clear,
    output logic                          o_busy,
    input  logic                          i_dbg_req,
    input  logic [NB_DEPTH-1:0]           i_dbg_addr,
    output logic                          o_dbg_valid,
    output logic [NB_BITS-1:0]            o_dbg_data
);

    localparam int RF_DEPTH = 2**NB_DEPTH;
    localparam logic [NB_DEPTH-1:0] LAST_IDX = NB_DEPTH'(RF_DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [NB_DEPTH-1:0]  r_cnt;
    logic [NB_BITS-1:0]   r_mem [RF_DEPTH];
    logic [NB_BITS-1:0]   w_rd [NB_RPORTS];
    logic [NB_BITS-1:0]   w_dbg;
    logic                 w_busy;
    logic                 w_start;
    logic                 w_byp_en;
    logic                 w_wr;

    // Post-bypass read value; busy forces zero, and entry 0 is zero when hardwired.
    function automatic logic [NB_BITS-1:0] f_read(
        input logic [NB_BITS-1:0]  stored,
        input logic [NB_DEPTH-1:0] addr,
        input logic                byp_en,
        input logic [NB_DEPTH-1:0] byp_addr,
        input logic [NB_BITS-1:0]  byp_data,
        input logic                busy
    );
        logic [NB_BITS-1:0] v;
        v = stored;
        if (byp_en && (byp_addr == addr)) v = byp_data;
`ifdef RF_ZERO_REG_EN
        if (addr == '0) v = '0;
`endif
        if (busy) v = '0;
        return v;
    endfunction

    assign w_busy   = (r_state == CLEAR);
    assign w_start  = (r_state == IDLE) && i_clear;
    assign w_byp_en = i_wenb && !w_busy;
`ifdef RF_ZERO_REG_EN
    assign w_wr     = w_byp_en && !w_start && (i_waddr != '0);
`else
    assign w_wr     = w_byp_en && !w_start;
`endif

    genvar k;
    generate
        for (k = 0; k < NB_RPORTS; k++) begin : g_rport
            assign w_rd[k] = f_read(r_mem[i_raddr[k*NB_DEPTH +: NB_DEPTH]],
                                    i_raddr[k*NB_DEPTH +: NB_DEPTH],
                                    w_byp_en, i_waddr, i_data, w_busy);
            assign o_rdata[k*NB_BITS +: NB_BITS] = w_rd[k];
        end
    endgenerate

    assign o_eq   = (w_rd[0] == w_rd[1]);
    assign o_busy = w_busy;
    assign w_dbg  = f_read(r_mem[i_dbg_addr], i_dbg_addr, w_byp_en, i_waddr, i_data, 1'b0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_clear) w_next = CLEAR;
            CLEAR:   if (r_cnt == LAST_IDX) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= NB_DEPTH'(1);
        end else if (w_busy) begin
            r_cnt <= r_cnt + NB_DEPTH'(1);
        end
    end

    // Clear sweep owns the array while running; entry 0 is zeroed on the request edge itself.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RF_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_start) begin
            r_mem[0] <= '0;
        end else if (w_busy) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr) begin
            r_mem[i_waddr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dbg_valid <= 1'b0;
            o_dbg_data  <= '0;
        end else begin
            o_dbg_valid <= i_dbg_req && !w_busy;
            if (i_dbg_req && !w_busy) o_dbg_data <= w_dbg;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: stimulus queues expectations, a negedge monitor checks them.
module tb_register_file_mp;

    localparam int NB_BITS   = 32;
    localparam int NB_DEPTH  = 5;
    localparam int NB_RPORTS = 2;
`ifdef RF_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NB_RPORTS*NB_DEPTH-1:0] raddr;
    logic [NB_RPORTS*NB_BITS-1:0]  rdata;
    logic                          eq;
    logic [NB_DEPTH-1:0]           waddr;
    logic [NB_BITS-1:0]            wdata;
    logic                          wenb;
    logic                          clear;
    logic                          busy;
    logic                          dbg_req;
    logic [NB_DEPTH-1:0]           dbg_addr;
    logic                          dbg_valid;
    logic [NB_BITS-1:0]            dbg_data;

    register_file_mp #(.NB_BITS(NB_BITS), .NB_DEPTH(NB_DEPTH), .NB_RPORTS(NB_RPORTS)) dut (
        .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata), .o_eq(eq),
        .i_waddr(waddr), .i_data(wdata), .i_wenb(wenb), .i_clear(clear), .o_busy(busy),
        .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .o_dbg_valid(dbg_valid), .o_dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;   // 0 rdata0, 1 rdata1, 2 eq, 3 busy, 4 dbg_valid, 5 dbg_data
        logic [31:0] exp;
    } chk_t;

    chk_t        q[$];
    logic [31:0] dbgq[$];
    int          nchk  = 0;
    int          npass = 0;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0:       return rdata[31:0];
            1:       return rdata[63:32];
            2:       return {31'd0, eq};
            3:       return {31'd0, busy};
            4:       return {31'd0, dbg_valid};
            default: return dbg_data;
        endcase
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic expect_out(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name; c.sel = sel; c.exp = exp;
        q.push_back(c);
    endtask

    // Monitor: consumes queued expectations and checks every debug valid pulse.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                chk_t c;
                c = q.pop_front();
                compare(c.name, pick(c.sel), c.exp);
            end
            if (dbg_valid === 1'b1) begin
                if (dbgq.size() == 0) compare("dbg_unexpected_valid", 32'd1, 32'd0);
                else compare("dbg_data", dbg_data, dbgq.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wenb = 1'b0; clear = 1'b0; dbg_req = 1'b0;
    endtask

    task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i < 31; i++) begin
            cyc(); idle_inputs();
            if (i == 3) begin
                wenb = 1'b1; waddr = 5'd7; wdata = 32'h55; set_raddr(5'd7, 5'd7);
                expect_out({tag, "_rd_busy"}, 0, 32'd0);
                expect_out({tag, "_eq_busy"}, 2, 32'd1);
            end
            expect_out({tag, "_busy_hi"}, 3, 32'd1);
        end
        cyc(); idle_inputs();
        expect_out({tag, "_busy_lo"}, 3, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; idle_inputs(); waddr = '0; wdata = '0; dbg_addr = '0;
        set_raddr(5'd3, 5'd3);
        #1;
        expect_out("rst_rd0", 0, 32'd0);
        expect_out("rst_rd1", 1, 32'd0);
        expect_out("rst_eq", 2, 32'd1);
        expect_out("rst_busy", 3, 32'd0);
        expect_out("rst_dbgv", 4, 32'd0);
        cyc(); cyc();
        rst = 1'b0;

        // Bypass then stored value
        cyc();
        wenb = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; set_raddr(5'd5, 5'd6);
        expect_out("byp_rd0", 0, 32'hDEADBEEF);
        expect_out("byp_rd1", 1, 32'd0);
        expect_out("byp_eq", 2, 32'd0);
        cyc(); idle_inputs();
        expect_out("stored_rd0", 0, 32'hDEADBEEF);

        // Fill 1..31 with index, then sweep
        for (int i = 1; i < 32; i++) begin
            cyc(); wenb = 1'b1; waddr = 5'(i); wdata = 32'(i);
        end
        cyc(); idle_inputs(); set_raddr(5'd7, 5'd31);
        expect_out("fill_rd7", 0, 32'd7);
        expect_out("fill_rd31", 1, 32'd31);
        expect_out("fill_eq", 2, 32'd0);
        cyc(); clear = 1'b1;
        expect_out("clr_req_busy", 3, 32'd0);
        sweep_check("clr1");
        for (int a = 0; a < 32; a += 2) begin
            cyc(); set_raddr(5'(a), 5'(a + 1));
            expect_out("post_clr_rd0", 0, 32'd0);
            expect_out("post_clr_rd1", 1, 32'd0);
        end

        // Reset mid-sweep, then a fresh sweep
        cyc(); wenb = 1'b1; waddr = 5'd2; wdata = 32'hA5;
        cyc(); waddr = 5'd0; wdata = 32'h11;
        cyc(); waddr = 5'd1; wdata = 32'h22;
        cyc(); idle_inputs(); clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(); idle_inputs();
        end
        rst = 1'b1; set_raddr(5'd2, 5'd1);
        expect_out("midrst_busy", 3, 32'd0);
        expect_out("midrst_rd2", 0, 32'd0);
        expect_out("midrst_rd1", 1, 32'd0);
        cyc();
        rst = 1'b0;
        cyc(); wenb = 1'b1; waddr = 5'd0; wdata = 32'h33;
        cyc(); idle_inputs(); clear = 1'b1;
        sweep_check("clr2");
        set_raddr(5'd0, 5'd2);
        expect_out("clr2_rd0", 0, 32'd0);

        // Debug port: same-cycle write included, back-to-back, drop while busy
        cyc(); dbg_req = 1'b1; dbg_addr = 5'd9; wenb = 1'b1; waddr = 5'd9; wdata = 32'h1234;
        dbgq.push_back(32'h1234);
        cyc(); wenb = 1'b1; waddr = 5'd4; wdata = 32'h4444; dbg_addr = 5'd9;
        expect_out("dbg_v1", 4, 32'd1);
        dbgq.push_back(32'h1234);
        cyc(); wenb = 1'b0; dbg_addr = 5'd4;
        expect_out("dbg_v2", 4, 32'd1);
        dbgq.push_back(32'h4444);
        cyc(); idle_inputs();
        expect_out("dbg_v3", 4, 32'd1);
        cyc();
        expect_out("dbg_v_low", 4, 32'd0);
        clear = 1'b1;
        cyc(); idle_inputs(); dbg_req = 1'b1; dbg_addr = 5'd9;
        cyc(); idle_inputs();
        expect_out("dbg_busy_novalid", 4, 32'd0);
        expect_out("dbg_busy_hold", 5, 32'h4444);
        for (int i = 0; i < 31; i++) cyc();
        expect_out("dbg_sweep_done", 3, 32'd0);

        // Entry 0 write
        cyc(); wenb = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; set_raddr(5'd0, 5'd1);
        expect_out("zero_byp", 0, ZR ? 32'd0 : 32'hFFFFFFFF);
        cyc(); idle_inputs();
        expect_out("zero_stored", 0, ZR ? 32'd0 : 32'hFFFFFFFF);
        cyc(); cyc();
        if (dbgq.size() != 0) compare("dbg_pending", 32'(dbgq.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
